// File: rtl/alert_pkg.sv
// alert_pkg: state encodings and alert code constants shared by the alert responder.
package alert_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_DOOR_ON, S_DOOR_OFF, S_MUTED} state_t;
    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_DOOR   = 2'b01;
    localparam logic [1:0] CODE_WEIGHT = 2'b10;
    localparam logic [1:0] CODE_MUTED  = 2'b11;
endpackage

// File: rtl/alert_tick_gen.sv
// alert_tick_gen: prescaler pulsing tick every TICK_DIV cycles, restartable by a sync clear.
module alert_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == W'(TICK_DIV - 1);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/alert_responder.sv
// alert_responder: turns door/weight alerts into buzzer pattern, lamps, code and interlocks.
module alert_responder
    import alert_pkg::*;
#(
    parameter int TICK_DIV       = 100_000,
    parameter int BEEP_ON_TICKS  = 200,
    parameter int BEEP_OFF_TICKS = 300,
    parameter int MUTE_TICKS     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       DOOR_ALERT,
    input  logic       WEIGHT_ALERT,
    input  logic       ACK,
    output logic       BUZZER,
    output logic       LED_DOOR,
    output logic       LED_WEIGHT,
    output logic       MOTION_INHIBIT,
    output logic       DOOR_HOLD_OPEN,
    output logic [1:0] ALERT_CODE
);
    localparam int  MAX_ON  = BEEP_ON_TICKS > BEEP_OFF_TICKS ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
    localparam int  MAX_T   = MAX_ON > MUTE_TICKS ? MAX_ON : MUTE_TICKS;
    localparam int  CW      = $clog2(MAX_T + 1);
    localparam bit  MUTE_EN = MUTE_TICKS > 0;

    logic door_q, weight_q, ack_q, ack_rise, tick, done;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, lim;
    logic buzzer_q, buzzer_d, led_door_q, led_door_d, led_weight_q, led_weight_d;
    logic inhibit_q, inhibit_d, hold_q, hold_d;
    logic [1:0] code_q, code_d;

    alert_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .tick(tick)
    );

    always_comb begin
        ack_rise = ACK & ~ack_q;
        lim = state_q == S_DOOR_ON  ? CW'(BEEP_ON_TICKS - 1) :
              state_q == S_DOOR_OFF ? CW'(BEEP_OFF_TICKS - 1) : CW'(MUTE_TICKS - 1);
        done = tick && cnt_q == lim;
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WEIGHT:
                state_d = weight_q ? S_WEIGHT : door_q ? S_DOOR_ON : S_IDLE;
            S_DOOR_ON, S_DOOR_OFF:
                state_d = weight_q ? S_WEIGHT : !door_q ? S_IDLE :
                          (ack_rise && MUTE_EN) ? S_MUTED : !done ? state_q :
                          state_q == S_DOOR_ON ? S_DOOR_OFF : S_DOOR_ON;
            S_MUTED:
                state_d = weight_q ? S_WEIGHT : !door_q ? S_IDLE : done ? S_DOOR_ON : S_MUTED;
            default: state_d = S_IDLE;
        endcase
        // every state entry restarts its phase from zero
        cnt_d = state_d != state_q ? '0 : (tick && cnt_q != lim) ? cnt_q + 1'b1 : cnt_q;
        buzzer_d     = state_d == S_WEIGHT || state_d == S_DOOR_ON;
        led_door_d   = state_d == S_WEIGHT ? door_q : state_d != S_IDLE;
        led_weight_d = state_d == S_WEIGHT;
        inhibit_d    = state_d != S_IDLE;
        hold_d       = state_d == S_WEIGHT;
        code_d = state_d == S_IDLE   ? CODE_NONE :
                 state_d == S_WEIGHT ? CODE_WEIGHT :
                 state_d == S_MUTED  ? CODE_MUTED : CODE_DOOR;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            door_q       <= 1'b0;
            weight_q     <= 1'b0;
            ack_q        <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            buzzer_q     <= 1'b0;
            led_door_q   <= 1'b0;
            led_weight_q <= 1'b0;
            inhibit_q    <= 1'b0;
            hold_q       <= 1'b0;
            code_q       <= CODE_NONE;
        end else begin
            door_q       <= DOOR_ALERT;
            weight_q     <= WEIGHT_ALERT;
            ack_q        <= ACK;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buzzer_q     <= buzzer_d;
            led_door_q   <= led_door_d;
            led_weight_q <= led_weight_d;
            inhibit_q    <= inhibit_d;
            hold_q       <= hold_d;
            code_q       <= code_d;
        end

    assign BUZZER         = buzzer_q;
    assign LED_DOOR       = led_door_q;
    assign LED_WEIGHT     = led_weight_q;
    assign MOTION_INHIBIT = inhibit_q;
    assign DOOR_HOLD_OPEN = hold_q;
    assign ALERT_CODE     = code_q;
endmodule

// File: tb/tb_alert_responder.sv
// tb_alert_responder: scoreboard bench; expected output vectors are queued per cycle as stimulus is driven.
module tb_alert_responder;
    // vector = {BUZZER, LED_DOOR, LED_WEIGHT, MOTION_INHIBIT, DOOR_HOLD_OPEN, ALERT_CODE}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_DON  = 7'b1101001;
    localparam logic [6:0] V_DOFF = 7'b0101001;
    localparam logic [6:0] V_MUTE = 7'b0101011;
    localparam logic [6:0] V_WGTD = 7'b1111110;

    logic clk = 0, rst = 1, door = 0, weight = 0, ack = 0;
    logic door2 = 0, weight2 = 0, ack2 = 0;
    logic bz1, ld1, lw1, mi1, dh1, bz2, ld2, lw2, mi2, dh2;
    logic [1:0] cd1, cd2;
    logic [6:0] o1, o2;
    int cyc = 0, checks = 0, errors = 0;

    typedef struct {int cyc; bit sel; logic [6:0] val; string tag;} exp_t;
    exp_t sb[$];

    alert_responder #(.TICK_DIV(4), .BEEP_ON_TICKS(2), .BEEP_OFF_TICKS(3), .MUTE_TICKS(5)) dut (
        .clk(clk), .rst(rst), .DOOR_ALERT(door), .WEIGHT_ALERT(weight), .ACK(ack),
        .BUZZER(bz1), .LED_DOOR(ld1), .LED_WEIGHT(lw1), .MOTION_INHIBIT(mi1),
        .DOOR_HOLD_OPEN(dh1), .ALERT_CODE(cd1)
    );
    alert_responder #(.TICK_DIV(4), .BEEP_ON_TICKS(2), .BEEP_OFF_TICKS(3), .MUTE_TICKS(0)) dut_nomute (
        .clk(clk), .rst(rst), .DOOR_ALERT(door2), .WEIGHT_ALERT(weight2), .ACK(ack2),
        .BUZZER(bz2), .LED_DOOR(ld2), .LED_WEIGHT(lw2), .MOTION_INHIBIT(mi2),
        .DOOR_HOLD_OPEN(dh2), .ALERT_CODE(cd2)
    );
    assign o1 = {bz1, ld1, lw1, mi1, dh1, cd1};
    assign o2 = {bz2, ld2, lw2, mi2, dh2, cd2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%07b exp=%07b", tag, got, exp);
        end
    endtask

    task automatic expect_span(bit sel, logic [6:0] v, int from, int to, string tag);
        for (int c = from; c <= to; c++) sb.push_back('{c, sel, v, tag});
    endtask

    task automatic goto(int n);
        while (cyc < n) @(negedge clk);
    endtask

    always begin
        int i;
        @(negedge clk);
        #1;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("%s@%0d", sb[i].tag, cyc), 32'(sb[i].sel ? o2 : o1), 32'(sb[i].val));
                sb.delete(i);
            end else i++;
        end
    end

    initial begin
        expect_span(0, V_IDLE, 1, 4, "reset");
        expect_span(1, V_IDLE, 1, 4, "reset_nm");
        goto(2);  rst = 0;
        goto(5);  door = 1;
        expect_span(0, V_IDLE, 5, 6, "t1_pre");
        expect_span(0, V_DON, 7, 14, "t1_on");
        expect_span(0, V_DOFF, 15, 26, "t1_off");
        expect_span(0, V_DON, 27, 34, "t1_on2");
        expect_span(0, V_DOFF, 35, 37, "t1_off2");
        goto(37); ack = 1;
        expect_span(0, V_MUTE, 38, 57, "t2_mute");
        expect_span(0, V_DON, 58, 65, "t2_on");
        expect_span(0, V_DOFF, 66, 68, "t2_off");
        goto(38); ack = 0;
        goto(45); ack = 1;
        goto(46); ack = 0;
        goto(68); ack = 1;
        expect_span(0, V_MUTE, 69, 76, "t3_mute");
        expect_span(0, V_WGTD, 77, 91, "t3_wgt");
        expect_span(0, V_DON, 92, 99, "t3_on");
        expect_span(0, V_DOFF, 100, 102, "t3_off");
        goto(69); ack = 0;
        goto(75); weight = 1;
        goto(80); ack = 1;
        goto(81); ack = 0;
        goto(90); weight = 0;
        goto(101); door = 0;
        expect_span(0, V_IDLE, 103, 109, "t4_idle");
        goto(108); door = 1; weight = 1;
        expect_span(0, V_WGTD, 110, 171, "t4_wgt");
        expect_span(0, V_DON, 172, 179, "t4_on");
        expect_span(0, V_DOFF, 180, 181, "t4_off");
        goto(112); ack = 1;
        goto(162); ack = 0;
        goto(170); weight = 0;
        goto(182); rst = 1;
        expect_span(0, V_IDLE, 182, 186, "t5_rst");
        expect_span(1, V_IDLE, 182, 211, "t5_rst_nm");
        expect_span(0, V_DON, 187, 194, "t5_on");
        expect_span(0, V_DOFF, 195, 206, "t5_off");
        goto(183); ack = 1;
        goto(185); rst = 0;
        goto(190); ack = 0;
        goto(210); door2 = 1;
        expect_span(1, V_DON, 212, 219, "t6_on");
        expect_span(1, V_DOFF, 220, 231, "t6_off");
        expect_span(1, V_DON, 232, 236, "t6_on2");
        expect_span(1, V_IDLE, 237, 240, "t6_idle");
        goto(215); ack2 = 1;
        goto(216); ack2 = 0;
        goto(235); door2 = 0;
        goto(242);
        check("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
